// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the button conditioning bank.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  // Bits needed to hold the larger of the two repeat intervals.
  function automatic int cnt_width(input int dly, input int rate);
    int big;
    big = (dly > rate) ? dly : rate;
    return $clog2(big + 1);
  endfunction

endpackage

// File: rtl/btn_cond_chan.sv
// One button channel: 2-flop synchroniser, tick-sampled debounce,
// press/release pulses and an optional hold-to-repeat FSM.
module btn_cond_chan
  import btn_cond_pkg::*;
#(
  parameter int DB_TICKS    = 2,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10,
  parameter bit RPT_EN      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic act
);

  localparam int RPT_W = cnt_width(REPEAT_DLY, REPEAT_RATE);
  localparam logic [3:0]       DB_LAST   = 4'(DB_TICKS - 1);
  localparam logic [RPT_W-1:0] DLY_LAST  = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  logic             sync1;
  logic             sync2;
  logic [3:0]       db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  rpt_state_t       state;

  logic differ;
  logic accept;
  logic press_evt;
  logic rel_evt;
  logic rpt_evt;

  assign differ    = sync2 ^ level;
  assign accept    = tick & differ & (db_cnt == DB_LAST);
  assign press_evt = accept & sync2;
  assign rel_evt   = accept & ~sync2;

  // A release on the same tick suppresses any repeat that falls due.
  always_comb begin
    rpt_evt = 1'b0;
    if (tick && !rel_evt) begin
      case (state)
        WAIT:    rpt_evt = (rpt_cnt == DLY_LAST);
        RPT:     rpt_evt = (rpt_cnt == RATE_LAST);
        default: rpt_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_cnt  <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      act     <= 1'b0;
      rpt_cnt <= '0;
      state   <= IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      press <= press_evt;
      rel   <= rel_evt;
      act   <= press_evt | rpt_evt;

      if (tick) begin
        if (!differ) begin
          db_cnt <= '0;
        end else if (accept) begin
          level  <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          rpt_cnt <= '0;
          if (press_evt && RPT_EN) state <= WAIT;
        end
        WAIT, RPT: begin
          if (rel_evt) begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end else if (tick) begin
            if (rpt_evt) begin
              rpt_cnt <= '0;
              state   <= RPT;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_cond_bank.sv
// Bank of N_BTN button conditioners sharing one free-running prescaler
// whose all-ones state provides the slow-rate tick.
module btn_cond_bank
  import btn_cond_pkg::*;
#(
  parameter int               N_BTN       = 5,
  parameter int               TICK_W      = 20,
  parameter int               DB_TICKS    = 2,
  parameter int               REPEAT_DLY  = 50,
  parameter int               REPEAT_RATE = 10,
  parameter logic [N_BTN-1:0] REPEAT_EN   = {N_BTN{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act
);

  logic [TICK_W-1:0] pre_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_cnt <= '0;
    else          pre_cnt <= pre_cnt + TICK_W'(1);
  end

  // Decoded from a register, so the strobe cannot glitch.
  assign tick = &pre_cnt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_cond_chan #(
      .DB_TICKS   (DB_TICKS),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE),
      .RPT_EN     (REPEAT_EN[i])
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .btn_in (btn_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .act    (btn_act[i])
    );
  end

endmodule

// File: tb/tb_btn_cond_bank.sv
// Directed bench for btn_cond_bank: tick phase, clean press/release,
// bounce rejection, hold-to-repeat, release-on-due-tick and async reset.
module tb_btn_cond_bank;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] btn_in = 2'b00;
  logic       tick;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_act;

  int checks = 0;
  int failures = 0;

  int act0_n = 0;
  int act1_n = 0;
  int press0_n = 0;
  int rel0_n = 0;
  int consec_n = 0;
  logic act0_prev = 1'b0;
  logic act1_prev = 1'b0;

  int p0;
  int r0;
  int a0;
  int a1;

  btn_cond_bank #(
    .N_BTN      (2),
    .TICK_W     (3),
    .DB_TICKS   (2),
    .REPEAT_DLY (4),
    .REPEAT_RATE(2),
    .REPEAT_EN  (2'b01)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .tick       (tick),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_act    (btn_act)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Pulse counters sample the pre-edge output values.
  always @(posedge clk) begin
    if (btn_act[0]) act0_n++;
    if (btn_act[1]) act1_n++;
    if (btn_press[0]) press0_n++;
    if (btn_release[0]) rel0_n++;
    if ((btn_act[0] && act0_prev) || (btn_act[1] && act1_prev)) consec_n++;
    act0_prev = btn_act[0];
    act1_prev = btn_act[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge just after the next tick edge.
  task automatic to_tick_edge();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL tick_wait observed=timeout expected=tick");
    end
    @(negedge clk);
  endtask

  initial begin
    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);
    check("rst_release", 32'(btn_release), 32'd0);
    check("rst_act", 32'(btn_act), 32'd0);
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check("tick_phase", 32'(tick), (i % 8 == 7) ? 32'd1 : 32'd0);
    end
    check("idle_outputs", 32'({btn_level, btn_press, btn_release, btn_act}), 32'd0);

    // clean press and release on channel 0
    btn_in = 2'b01;
    to_tick_edge();
    check("press_early", 32'({btn_level, btn_press, btn_act}), 32'd0);
    to_tick_edge();
    check("press_pulse", 32'(btn_press), 32'd1);
    check("press_level", 32'(btn_level), 32'd1);
    check("press_act", 32'(btn_act), 32'd1);
    @(negedge clk);
    check("press_one_cycle", 32'({btn_press, btn_act}), 32'd0);
    btn_in = 2'b00;
    to_tick_edge();
    check("release_early", 32'({btn_level, btn_release}), 32'b0100);
    to_tick_edge();
    check("release_pulse", 32'(btn_release), 32'd1);
    check("release_level", 32'(btn_level), 32'd0);
    check("release_no_act", 32'(btn_act), 32'd0);
    @(negedge clk);
    check("release_one_cycle", 32'(btn_release), 32'd0);

    // bounce: toggle every 3 cycles for 30 cycles, then settle high
    to_tick_edge();
    p0 = press0_n;
    r0 = rel0_n;
    a0 = act0_n;
    for (int j = 0; j < 10; j++) begin
      btn_in[0] = (j % 2 == 0);
      repeat (3) @(negedge clk);
    end
    btn_in[0] = 1'b1;
    repeat (17) @(negedge clk);
    check("bounce_level", 32'(btn_level), 32'd0);
    check("bounce_no_press", 32'(press0_n - p0), 32'd0);
    check("bounce_no_release", 32'(rel0_n - r0), 32'd0);
    check("bounce_no_act", 32'(act0_n - a0), 32'd0);
    @(negedge clk);
    check("bounce_press", 32'(btn_press), 32'd1);
    check("bounce_press_level", 32'(btn_level), 32'd1);
    @(negedge clk);
    btn_in = 2'b00;
    to_tick_edge();
    to_tick_edge();
    check("bounce_release", 32'(btn_release), 32'd1);
    @(negedge clk);
    check("bounce_press_count", 32'(press0_n - p0), 32'd1);
    check("bounce_release_count", 32'(rel0_n - r0), 32'd1);

    // hold both channels; only channel 0 repeats
    to_tick_edge();
    btn_in = 2'b11;
    a0 = act0_n;
    a1 = act1_n;
    to_tick_edge();
    check("hold_db_phase", 32'(btn_act), 32'd0);
    to_tick_edge();
    check("hold_press", 32'(btn_press), 32'b11);
    check("hold_act_t0", 32'(btn_act), 32'b11);
    for (int k = 1; k <= 18; k++) begin
      if (k == 18) btn_in = 2'b00;
      to_tick_edge();
      check($sformatf("hold_act_t%0d", k), 32'(btn_act),
            ((k == 4) || (k >= 6 && k % 2 == 0)) ? 32'b01 : 32'b00);
    end
    to_tick_edge();
    check("hold_release", 32'(btn_release), 32'b11);
    check("hold_release_no_act", 32'(btn_act), 32'd0);
    @(negedge clk);
    check("hold_act0_count", 32'(act0_n - a0), 32'd9);
    check("hold_act1_count", 32'(act1_n - a1), 32'd1);

    // release lands on the tick a repeat is due
    to_tick_edge();
    btn_in = 2'b01;
    to_tick_edge();
    to_tick_edge();
    check("due_press_act", 32'(btn_act), 32'b01);
    for (int k = 1; k <= 4; k++) begin
      to_tick_edge();
      check($sformatf("due_act_s%0d", k), 32'(btn_act), (k == 4) ? 32'b01 : 32'b00);
    end
    btn_in = 2'b00;
    to_tick_edge();
    check("due_db_phase", 32'({btn_release, btn_act}), 32'd0);
    to_tick_edge();
    check("due_release", 32'(btn_release), 32'b01);
    check("due_release_wins", 32'(btn_act), 32'd0);
    check("due_level", 32'(btn_level), 32'd0);
    for (int k = 7; k <= 10; k++) begin
      to_tick_edge();
      check($sformatf("due_idle_s%0d", k), 32'(btn_act), 32'd0);
    end

    // asynchronous reset in the middle of a repeat hold
    btn_in = 2'b01;
    to_tick_edge();
    to_tick_edge();
    check("mid_press_act", 32'(btn_act), 32'b01);
    for (int k = 1; k <= 4; k++) to_tick_edge();
    check("mid_first_repeat", 32'(btn_act), 32'b01);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("mid_reset_outputs", 32'({tick, btn_level, btn_press, btn_release, btn_act}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_reset_hold", 32'({tick, btn_level, btn_press, btn_release, btn_act}), 32'd0);
    reset_n = 1'b1;
    p0 = press0_n;
    to_tick_edge();
    check("post_reset_db", 32'({btn_level, btn_press}), 32'd0);
    to_tick_edge();
    check("post_reset_press", 32'(btn_press), 32'b01);
    check("post_reset_act", 32'(btn_act), 32'b01);
    check("post_reset_level", 32'(btn_level), 32'b01);
    @(negedge clk);
    check("post_reset_press_count", 32'(press0_n - p0), 32'd1);

    check("act_never_back_to_back", 32'(consec_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_cond_bank.md
Name: btn_cond_bank

Overview:
- Parametrised successor to the board-level button edge detectors. Replaces the divided-clock-plus-flop-pair scheme with a single-clock design that uses a clock-enable tick.
- Conditions N_BTN raw pushbuttons: 2-flop synchronisation, tick-sampled debounce, clean press/release pulses, and optional per-button hold-to-repeat.
- Sits between the board top level and game/application FSMs. Those FSMs stay on the fast clock and consume single-cycle pulses.

Parameters:
- N_BTN, 5, number of button channels.
- TICK_W, 20, prescaler width. Tick period is 2**TICK_W clk cycles.
- DB_TICKS, 2, consecutive differing tick samples needed to accept a level change. Legal range 1..15.
- REPEAT_DLY, 50, ticks of continuous hold from press to first repeat pulse. Must be >= 1.
- REPEAT_RATE, 10, ticks between subsequent repeat pulses. Must be >= 1.
- REPEAT_EN, {N_BTN{1'b0}}, per-button mask. A bit set to 1 enables auto-repeat for that channel.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset. Deassertion is externally synchronised.
- btn_in  in  N_BTN  raw, asynchronous, bouncy button levels; 1 = pressed.
- tick  out  1  one-cycle prescaler strobe, exported for other slow-rate logic.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on a debounced 0->1 transition.
- btn_release  out  N_BTN  one-cycle pulse on a debounced 1->0 transition.
- btn_act  out  N_BTN  one-cycle pulse, equal to btn_press OR repeat event. This is the port for menu/guess inputs.

Behaviour:
- Reset (reset_n=0): immediate, asynchronous. Sync flops, prescaler, debounce counters, repeat counters, states and all outputs go to 0. Reset mid-hold aborts everything; the first press after reset is reported normally.
- Synchroniser: two flops per bit, clocked every cycle. sync = second-stage flop.
- Prescaler: TICK_W-bit up-counter, wraps. tick=1 in the cycle where the counter equals all-ones; the counter then wraps to 0. tick is combinational from the registered counter, so it is glitch-free.
- Debounce, per channel, on tick cycles only:
  - If sync != btn_level: db_cnt <= db_cnt+1.
  - If sync == btn_level: db_cnt <= 0.
  - When db_cnt+1 == DB_TICKS while differing: btn_level <= sync, db_cnt <= 0, and btn_press (or btn_release) is registered high for exactly that one following cycle.
  - Glitches entirely between ticks are invisible.
  - Latency from a stable input change to the pulse: at most 2 + DB_TICKS*2**TICK_W + 1 cycles.
- Repeat FSM, per channel; only active when REPEAT_EN[i]=1, otherwise it stays in IDLE. States:
  - IDLE -> WAIT on press event; rpt_cnt <= 0.
  - WAIT: on each tick, if rpt_cnt+1 == REPEAT_DLY then emit repeat pulse, rpt_cnt <= 0, go to RPT; else rpt_cnt++.
  - RPT: on each tick, if rpt_cnt+1 == REPEAT_RATE then emit repeat pulse, rpt_cnt <= 0; else rpt_cnt++.
  - Counter ticks start on the tick after the press tick.
  - A release event in WAIT or RPT goes to IDLE. On the same tick, release wins: no repeat pulse is issued.
- rpt_cnt width: $clog2(max(REPEAT_DLY,REPEAT_RATE)+1).
- btn_act = press | repeat, registered, exactly one cycle per event, never two consecutive cycles.
- Channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle.
- Outputs are registered, except tick.

Decomposition:
- Shared package btn_cond_pkg: repeat state enum (IDLE, WAIT, RPT) and a helper for the counter-width function.
- Sub-module btn_cond_chan holds one channel: synchroniser, debounce counter, level/press/release, repeat FSM.
- btn_cond_bank owns the single prescaler and generates N_BTN channels, feeding each the shared tick and its REPEAT_EN bit.

Test Plan:
Bench parameters: TICK_W=3 (tick every 8 cycles), DB_TICKS=2, REPEAT_DLY=4, REPEAT_RATE=2, N_BTN=2.
- Reset then idle: all outputs 0. tick is high for exactly 1 cycle in every 8, first at cycle 7 after reset release.
- Clean press: btn_in[0] 0->1 and held. btn_level[0] rises on the second tick after sync, with btn_press[0] and btn_act[0] high for exactly 1 cycle. Release gives a matching single btn_release[0] pulse.
- Bounce: btn_in[0] toggles at 3-cycle intervals for 30 cycles, then settles at 1. No pulses occur during the bounce; exactly one press follows after settling.
- Repeat with REPEAT_EN=2'b01 and button 0 held for 20 ticks: btn_act[0] fires at the press tick, then 4 ticks later, then every 2 ticks. That is 1+1+7 = 9 pulses before release. Channel 1, held identically, gets exactly 1 btn_act.
- Release on the exact tick a repeat is due: btn_release fires, no btn_act pulse, FSM is back in IDLE.
- reset_n pulsed low mid-repeat (asynchronous, between edges): all outputs 0 immediately. With the button still held after release of reset, exactly one btn_press follows after DB_TICKS ticks.
